// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg
// Shared types and helpers for the frequency meter:
//   conv_state_t - double-dabble converter states
//   max_count()  - largest count representable in ndig decimal digits
//   seg_decode() - BCD digit 0..9 to active-low {g,f,e,d,c,b,a}
//   SEG_BLANK    - all segments off
package freq_meter_pkg;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic int max_count(input int ndig);
        int p;
        p = 1;
        for (int i = 0; i < ndig; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/freq_meter_display_bcd_seq_conv.sv
// bcd_seq_conv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
//   CLK   in   system clock
//   RST   in   synchronous active-high reset, aborts a conversion
//   start in   load bin and begin converting (honoured in IDLE only)
//   bin   in   CNT_W-bit binary value, must be < 10**NDIG
//   bcd   out  4*NDIG-bit packed BCD result, valid while done is high
//   done  out  one-cycle strobe when bcd holds the finished result
//
// state      | meaning
// CONV_IDLE  | waiting for start
// CONV_SHIFT | CNT_W cycles of add-3 then shift-left
// CONV_DONE  | result presented for one cycle, then back to idle
module bcd_seq_conv
    import freq_meter_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int CNT_W = 14
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [CNT_W-1:0]  bin,
    output logic [4*NDIG-1:0] bcd,
    output logic              done
);

    localparam int SR_W   = 4*NDIG + CNT_W;
    localparam int STEP_W = $clog2(CNT_W + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CNT_W - 1);

    conv_state_t       state, state_nxt;
    logic [SR_W-1:0]   sr, sr_nxt;
    logic [STEP_W-1:0] step_cnt, step_cnt_nxt;

    // BCD digits live in the upper part of sr, the remaining binary bits
    // in the lower part; every digit >= 5 is corrected before the shift.
    function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] t;
        t = v;
        for (int i = 0; i < NDIG; i++) begin
            if (t[CNT_W + 4*i +: 4] >= 4'd5) begin
                t[CNT_W + 4*i +: 4] = t[CNT_W + 4*i +: 4] + 4'd3;
            end
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= CONV_IDLE;
            sr       <= '0;
            step_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sr       <= sr_nxt;
            step_cnt <= step_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sr_nxt       = sr;
        step_cnt_nxt = step_cnt;
        done         = 1'b0;
        case (state)
            CONV_IDLE: begin
                if (start) begin
                    sr_nxt       = {{(4*NDIG){1'b0}}, bin};
                    step_cnt_nxt = STEP_LAST;
                    state_nxt    = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                sr_nxt = dabble(sr);
                if (step_cnt == '0) begin
                    state_nxt = CONV_DONE;
                end else begin
                    step_cnt_nxt = step_cnt - 1'b1;
                end
            end
            CONV_DONE: begin
                done      = 1'b1;
                state_nxt = CONV_IDLE;
            end
            default: state_nxt = CONV_IDLE;
        endcase
    end

    assign bcd = sr[SR_W-1 -: 4*NDIG];

endmodule

// File: rtl/freq_meter_display.sv
// freq_meter_display
// Counts rising edges of an asynchronous input over a fixed gate window,
// converts the count to BCD and scans it onto an NDIG-digit multiplexed
// seven-segment display.
//   CLK    in   system clock
//   RST    in   synchronous active-high reset
//   IN     in   asynchronous signal under measurement
//   digits out  digit enables, active-low, one digit low at a time
//   SEG    out  segments {g,f,e,d,c,b,a}, active-low
//   OVF    out  last completed window saturated
//   VALID  out  one-cycle pulse when a new result reaches the display
// Build option: define LZ_BLANK_EN to blank leading zeros above digit 0.
module freq_meter_display
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES    = 100_000_000,
    parameter int REFRESH_CYCLES = 100_000,
    parameter int NDIG           = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN,
    output logic [NDIG-1:0] digits,
    output logic [6:0]      SEG,
    output logic            OVF,
    output logic            VALID
);

    localparam int CNT_W = $clog2(max_count(NDIG) + 1);
    localparam int GATE_W = $clog2(GATE_CYCLES + 1);
    localparam int REF_W  = $clog2(REFRESH_CYCLES + 1);
    localparam int IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NDIG - 1);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(max_count(NDIG));

    if (NDIG < 1 || NDIG > 6) begin : g_bad_ndig
        $error("freq_meter_display: NDIG must be 1..6");
    end
    // Conversion takes CNT_W+2 cycles and must end before the next window closes.
    if (GATE_CYCLES < CNT_W + 4) begin : g_bad_gate
        $error("freq_meter_display: GATE_CYCLES must be >= CNT_W+4");
    end
    if (REFRESH_CYCLES < 1) begin : g_bad_refresh
        $error("freq_meter_display: REFRESH_CYCLES must be >= 1");
    end

    logic              in_meta, in_sync, in_prev;
    logic [1:0]        arm_cnt;
    logic              edge_det;
    logic [GATE_W-1:0] gate_cnt;
    logic              terminal;
    logic [CNT_W-1:0]  edge_cnt, cnt_nxt;
    logic              ovf_win, ovf_nxt, snap_ovf;
    logic [4*NDIG-1:0] conv_bcd, disp_bcd;
    logic              conv_done;
    logic [REF_W-1:0]  ref_cnt;
    logic [IDX_W-1:0]  scan_idx;
    logic [3:0]        cur_digit;
    logic [6:0]        seg_nxt;

    // Edges are ignored until arm_cnt saturates, so a level already high
    // at reset release never looks like a fresh edge.
    assign edge_det = (arm_cnt == 2'd3) && in_sync && !in_prev;

    // gate_cnt holds the cycles remaining in the window; 0 is the terminal cycle.
    assign terminal = (gate_cnt == '0);

    always_comb begin
        cnt_nxt = edge_cnt;
        if (edge_det && edge_cnt != MAX_CNT) begin
            cnt_nxt = edge_cnt + 1'b1;
        end
        ovf_nxt = ovf_win | (edge_det && cnt_nxt == MAX_CNT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            in_meta  <= 1'b0;
            in_sync  <= 1'b0;
            in_prev  <= 1'b0;
            arm_cnt  <= '0;
            gate_cnt <= GATE_LAST;
            edge_cnt <= '0;
            ovf_win  <= 1'b0;
            snap_ovf <= 1'b0;
        end else begin
            in_meta <= IN;
            in_sync <= in_meta;
            in_prev <= in_sync;
            if (arm_cnt != 2'd3) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
            if (terminal) begin
                gate_cnt <= GATE_LAST;
                edge_cnt <= '0;
                ovf_win  <= 1'b0;
                snap_ovf <= ovf_nxt;
            end else begin
                gate_cnt <= gate_cnt - 1'b1;
                edge_cnt <= cnt_nxt;
                ovf_win  <= ovf_nxt;
            end
        end
    end

    // The converter latches cnt_nxt in the terminal cycle, so an edge seen
    // in that cycle is included in the closing window.
    bcd_seq_conv #(
        .NDIG  (NDIG),
        .CNT_W (CNT_W)
    ) u_conv (
        .CLK   (CLK),
        .RST   (RST),
        .start (terminal),
        .bin   (cnt_nxt),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            disp_bcd <= '0;
            OVF      <= 1'b0;
            VALID    <= 1'b0;
        end else begin
            VALID <= conv_done;
            if (conv_done) begin
                disp_bcd <= conv_bcd;
                OVF      <= snap_ovf;
            end
        end
    end

    always_comb begin
        cur_digit = disp_bcd[{scan_idx, 2'b00} +: 4];
        seg_nxt   = seg_decode(cur_digit);
`ifdef LZ_BLANK_EN
        if (scan_idx != '0 && (disp_bcd >> {scan_idx, 2'b00}) == '0) begin
            seg_nxt = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ref_cnt  <= REF_LAST;
            scan_idx <= '0;
            digits   <= '1;
            SEG      <= SEG_BLANK;
        end else begin
            if (ref_cnt == '0) begin
                ref_cnt  <= REF_LAST;
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
            end else begin
                ref_cnt <= ref_cnt - 1'b1;
            end
            digits <= ~(NDIG'(1) << scan_idx);
            SEG    <= seg_nxt;
        end
    end

endmodule

// File: doc/freq_meter_display.md
# freq_meter_display

Parametrised frequency meter. Counts rising edges of an asynchronous input over a fixed gate window and converts the count to BCD with a sequential double-dabble converter. Drives the result onto an NDIG-digit time-multiplexed seven-segment display. Next-generation top-level measurement/display block: configurable digit count, gate and refresh periods, an overflow flag and a measurement-valid strobe.

## Interface
- GATE_CYCLES, 100_000_000: gate window length in CLK cycles (1 s at 100 MHz); must be ≥ CNT_W+4.
- REFRESH_CYCLES, 100_000: dwell time per display digit, in CLK cycles.
- NDIG, 4: number of decimal digits; 1..6.
- CNT_W (localparam): $clog2(10**NDIG); 14 for NDIG=4.
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- IN  in  1  asynchronous signal under measurement.
- digits  out  NDIG  digit enables, active-low, one-hot-low while scanning.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
- OVF  out  1  last completed window saturated.
- VALID  out  1  one-cycle pulse when a new result is loaded into the display.

## Operation
- Synchronise IN through 2 flops, then detect rising edges. A level already high at reset release does not count; the edge detector arms 3 cycles after RST falls.
- Gate counter runs 0..GATE_CYCLES-1 and wraps. Edge counter increments on each detected edge and saturates at MAX = 10**NDIG-1.
  - Reaching MAX, or an edge arriving at MAX, sets a sticky per-window overflow bit.
- Terminal cycle T (gate counter = GATE_CYCLES-1):
  - Snapshot count+edge and the overflow bit.
  - Clear the edge counter and overflow bit.
  - Start conversion.
  - An edge detected in cycle T belongs to the closing window.
- Converter FSM:
  - IDLE: waits for start.
  - SHIFT: CNT_W cycles of add-3/shift.
  - DONE: 1 cycle; loads the display register and OVF, pulses VALID; returns to IDLE.
- Display register holds until the next DONE.
- Scan: refresh counter advances the digit index 0→NDIG-1→0 every REFRESH_CYCLES. Index 0 is the least-significant digit.
- digits drives bit[index] low and all other bits high. SEG carries the seven-segment code of that BCD digit.
- Codes outside 0–9 cannot occur.
- Reset (including mid-conversion or mid-window):
  - Aborts conversion; FSM goes to IDLE.
  - All counters and the display register go to 0; OVF=0, VALID=0.
  - digits = all ones; SEG = 7'h7F.

## Timing
- digits, SEG, OVF and VALID are registered.
- First cycle after RST deasserts: digits = ~1 (digit 0 enabled), SEG = '0' (7'b1000000).
- Latency: terminal cycle T → VALID high in cycle T+CNT_W+2, with the display and OVF updated in the same cycle.
- Conversion always finishes before the next terminal cycle (parameter constraint, checked at elaboration).
- Maximum countable rate: one edge per 2 CLK cycles (synchroniser limit).

## Configuration
- LZ_BLANK_EN defined: leading-zero digits above the most significant non-zero digit show SEG = 7'h7F. Digit 0 always shows a numeral, so 0 displays as a single "0".
- LZ_BLANK_EN undefined: all NDIG digits always show numerals, zero-padded.

## Structure
- Package freq_meter_pkg holds:
  - the converter state enum;
  - a max_count(NDIG) function;
  - the seven-segment decode function (0–9 to active-low gfedcba);
  - the SEG_BLANK constant.
- Sub-module bcd_seq_conv: the sequential double-dabble converter.
  - Ports: CLK, RST, start, bin[CNT_W], bcd[4*NDIG], done.
- Synchroniser, gate/edge counters and scan logic stay in the top.

## Test plan
Bench parameters: GATE_CYCLES=1000, REFRESH_CYCLES=4, NDIG=4, unless noted.
- IN square wave, period 10 cycles, for a full window → VALID once, display 0100, OVF=0. Scan shows digit 2 with SEG 7'b1111001.
- IN held high through and after reset → display 0000. With LZ_BLANK_EN: digits 3..1 show 7'h7F and digit 0 shows 7'b1000000.
- NDIG=2, GATE_CYCLES=1000, IN toggling every cycle (500 edges) → display 99, OVF=1. Next window with IN static → 00, OVF=0.
- Single edge whose detection lands exactly in terminal cycle T → counted in the closing window (display 0001), next window 0000.
- RST asserted 3 cycles into SHIFT → no VALID; digits=all ones, SEG=7'h7F during RST; display 0000 after release.
- Static display 1234 → digits sequence 1110, 1101, 1011, 0111, each held 4 cycles. SEG shows 4, 3, 2, 1 in turn; the pattern wraps.
